// File: rtl/ks_bus_responder.sv
// rtl/ks_bus_responder.sv - host bus register responder with a 128-word register file and an interrupt controller
// Strobes are synchronized and edge-detected; a small FSM runs command, data-write and data-read cycles.
module ks_bus_responder #(
    parameter logic [15:0] CHIP_ID     = 16'h8870,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk40m,
    input  logic        reset,
    input  logic        CSN,
    input  logic        CMD,
    input  logic        RDN,
    input  logic        WRN,
    input  logic [15:0] SD_in,
    output logic [15:0] SD_out,
    output logic        SD_oe,
    output logic        INTRN,
    input  logic [15:0] irq_set,
    output logic        proto_err
);
    typedef enum logic [2:0] {IDLE, CMD_WR, DATA_WR, DATA_RD, ERR} state_t;

    localparam int            SW          = 20;
    localparam logic [SW-1:0] SYNC_IDLE   = 20'hB_0000;
    localparam logic [7:0]    SETTLE_DONE = 8'(SYNC_STAGES + 1);
    localparam logic [6:0]    IER_IDX     = 7'h48;
    localparam logic [6:0]    ISR_IDX     = 7'h49;
    localparam logic [6:0]    CHIP_IDX    = 7'h60;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_d [SYNC_STAGES];
    logic [SW-1:0] sync_s;
    logic          csn_s, cmd_s, rdn_s, wrn_s;
    logic [15:0]   sd_s;

    logic          rdn_p_q, rdn_p_d, wrn_p_q, wrn_p_d;
    logic [7:0]    settle_q, settle_d;
    state_t        state_q, state_d;
    logic [6:0]    word_q, word_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   regs_q [128];
    logic [15:0]   regs_d [128];
    logic [15:0]   sd_out_q, sd_out_d;
    logic          sd_oe_q, sd_oe_d, intrn_q, intrn_d, proto_err_q, proto_err_d;

    logic          edge_ok, rd_fall, rd_rise, wr_fall, wr_rise, conflict, wr_commit;
    logic [15:0]   be_mask, rd_word, w1c_mask;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign {csn_s, cmd_s, rdn_s, wrn_s, sd_s} = sync_s;

    always_comb begin
        sync_d[0] = {CSN, CMD, RDN, WRN, SD_in};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // Edges are suppressed until the pipeline and the previous-value flops hold real samples,
    // so strobes that were already low at reset release never look like a fresh fall.
    assign edge_ok  = (settle_q == SETTLE_DONE);
    assign rd_fall  = edge_ok & rdn_p_q & ~rdn_s;
    assign rd_rise  = edge_ok & ~rdn_p_q & rdn_s;
    assign wr_fall  = edge_ok & wrn_p_q & ~wrn_s;
    assign wr_rise  = edge_ok & ~wrn_p_q & wrn_s;
    assign conflict = ~csn_s & ~rdn_s & ~wrn_s;
    assign be_mask  = {{8{be_q[1]}}, {8{be_q[0]}}};
    assign rd_word  = (word_q == CHIP_IDX) ? CHIP_ID : regs_q[word_q];

    always_comb begin
        rdn_p_d     = rdn_s;
        wrn_p_d     = wrn_s;
        settle_d    = edge_ok ? settle_q : settle_q + 8'd1;
        state_d     = state_q;
        word_d      = word_q;
        be_d        = be_q;
        sd_out_d    = sd_out_q;
        sd_oe_d     = 1'b0;
        wr_commit   = 1'b0;
        w1c_mask    = '0;
        regs_d      = regs_q;

        if (state_q == IDLE) begin
            if (conflict) begin
                state_d = ERR;
            end else if (!csn_s) begin
                if (wr_fall)               state_d = cmd_s ? CMD_WR : DATA_WR;
                else if (rd_fall && !cmd_s) state_d = DATA_RD;
            end
        end else if (csn_s) begin
            state_d = IDLE;
        end else if (conflict) begin
            state_d = ERR;
        end else begin
            case (state_q)
                CMD_WR: if (wr_rise) begin
                    word_d  = sd_s[7:1];
                    be_d    = sd_s[13:12];
                    state_d = IDLE;
                end
                DATA_WR: if (wr_rise) begin
                    wr_commit = 1'b1;
                    state_d   = IDLE;
                end
                DATA_RD: if (rd_rise) begin
                    state_d = IDLE;
                end else begin
                    sd_oe_d  = 1'b1;
                    sd_out_d = rd_word & be_mask;
                end
                ERR: if (rdn_s && wrn_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (wr_commit) begin
            if (word_q == ISR_IDX)
                w1c_mask = sd_s & be_mask;
            else if (word_q != CHIP_IDX)
                regs_d[word_q] = (regs_q[word_q] & ~be_mask) | (sd_s & be_mask);
        end
        // A same-cycle interrupt set overrides the clear.
        regs_d[ISR_IDX] = (regs_q[ISR_IDX] & ~w1c_mask) | irq_set;
        intrn_d     = ~|(regs_d[ISR_IDX] & regs_d[IER_IDX]);
        proto_err_d = (state_d == ERR) && (state_q != ERR);
    end

    always_ff @(posedge clk40m or posedge reset) begin
        if (reset) begin
            sync_q      <= '{default: SYNC_IDLE};
            rdn_p_q     <= 1'b1;
            wrn_p_q     <= 1'b1;
            settle_q    <= '0;
            state_q     <= IDLE;
            word_q      <= '0;
            be_q        <= 2'b11;
            regs_q      <= '{default: '0};
            sd_out_q    <= '0;
            sd_oe_q     <= 1'b0;
            intrn_q     <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rdn_p_q     <= rdn_p_d;
            wrn_p_q     <= wrn_p_d;
            settle_q    <= settle_d;
            state_q     <= state_d;
            word_q      <= word_d;
            be_q        <= be_d;
            regs_q      <= regs_d;
            sd_out_q    <= sd_out_d;
            sd_oe_q     <= sd_oe_d;
            intrn_q     <= intrn_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign SD_out    = sd_out_q;
    assign SD_oe     = sd_oe_q;
    assign INTRN     = intrn_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_ks_bus_responder.sv
// tb/tb_ks_bus_responder.sv - self-checking bench for ks_bus_responder against a transaction-level model
module tb_ks_bus_responder;
    localparam int S = 2;

    logic        clk40m = 1'b0;
    logic        reset, CSN, CMD, RDN, WRN;
    logic [15:0] SD_in, irq_set;
    logic [15:0] SD_out;
    logic        SD_oe, INTRN, proto_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mregs [128];
    logic [7:0]  moff;
    logic [1:0]  mbe;

    ks_bus_responder #(.CHIP_ID(16'h8870), .SYNC_STAGES(S)) dut (
        .clk40m(clk40m), .reset(reset), .CSN(CSN), .CMD(CMD), .RDN(RDN), .WRN(WRN),
        .SD_in(SD_in), .SD_out(SD_out), .SD_oe(SD_oe), .INTRN(INTRN),
        .irq_set(irq_set), .proto_err(proto_err)
    );

    always #5 clk40m = ~clk40m;

    function automatic logic [15:0] bemask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) mregs[i] = 16'h0;
        moff = 8'h00;
        mbe  = 2'b11;
    endfunction

    function automatic logic [15:0] model_read();
        int idx;
        idx = int'(moff) / 2;
        if (idx == 'h60) return 16'h8870 & bemask(mbe);
        return mregs[idx] & bemask(mbe);
    endfunction

    function automatic void model_write(input logic [15:0] d);
        int idx;
        logic [15:0] m;
        idx = int'(moff) / 2;
        m   = bemask(mbe);
        if (idx == 'h49)      mregs[idx] = mregs[idx] & ~(d & m);
        else if (idx != 'h60) mregs[idx] = (mregs[idx] & ~m) | (d & m);
    endfunction

    function automatic logic model_intrn();
        return ~|(mregs['h49] & mregs['h48]);
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk40m);
    endtask

    task automatic bus_cycle(input logic is_cmd, input logic [15:0] d);
        @(negedge clk40m);
        CSN = 1'b0; CMD = is_cmd; SD_in = d;
        hold(1); WRN = 1'b0;
        hold(3); WRN = 1'b1;
        hold(S + 4); CSN = 1'b1; CMD = 1'b0;
        hold(2);
    endtask

    task automatic bus_cmd(input logic [15:0] d);
        bus_cycle(1'b1, d);
        moff = d[7:0];
        mbe  = d[13:12];
    endtask

    task automatic bus_write(input logic [15:0] d);
        bus_cycle(1'b0, d);
        model_write(d);
    endtask

    task automatic bus_read(output logic [15:0] data, output int lat);
        @(negedge clk40m);
        CSN = 1'b0; CMD = 1'b0;
        hold(1); RDN = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk40m); #1;
            if (SD_oe === 1'b1) begin lat = i; break; end
        end
        data = SD_out;
        hold(2); RDN = 1'b1;
        hold(S + 4); CSN = 1'b1;
        hold(2);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int lat;
        reset = 1'b1; CSN = 1'b1; CMD = 1'b0; RDN = 1'b1; WRN = 1'b1;
        SD_in = 16'h0; irq_set = 16'h0;
        model_reset();
        hold(3);
        checks++;
        if (SD_oe !== 1'b0 || SD_out !== 16'h0 || INTRN !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got oe=%b out=%h intrn=%b perr=%b expected 0 0000 1 0",
                     SD_oe, SD_out, INTRN, proto_err);
        end
        reset = 1'b0;
        hold(2);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_word0: got %h expected 0000", d); end
        checks++;
        if (lat != S + 2) begin errors++; $display("FAIL reset_latency: got %0d expected %0d", lat, S + 2); end
    endtask

    task automatic test_chip_id();
        logic [15:0] d;
        int lat;
        bus_cmd(16'h30C0);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h8870) begin errors++; $display("FAIL chip_id: got %h expected 8870", d); end
        checks++;
        if (lat != S + 2) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, S + 2); end
        bus_write(16'hFFFF);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h8870) begin errors++; $display("FAIL chip_id_ro: got %h expected 8870", d); end
        bus_cmd(16'h10C1);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h0070) begin errors++; $display("FAIL chip_id_lowbyte: got %h expected 0070", d); end
    endtask

    task automatic test_byte_enable();
        logic [15:0] d;
        int lat;
        bus_cmd(16'h1010);
        bus_write(16'hABCD);
        bus_cmd(16'h3010);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h00CD) begin errors++; $display("FAIL be_low_write: got %h expected 00CD", d); end
        bus_cmd(16'h2010);
        bus_write(16'h5A11);
        bus_cmd(16'h3010);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h5ACD) begin errors++; $display("FAIL be_high_write: got %h expected 5ACD", d); end
    endtask

    task automatic test_random();
        logic [15:0] d, c, exp;
        logic [7:0]  off;
        int lat;
        for (int n = 0; n < 50; n++) begin
            if (n == 0 || $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       off = 8'hC0;
                    1:       off = ($urandom_range(0, 1) == 0) ? 8'h90 : 8'h92;
                    default: off = 8'($urandom_range(0, 15));
                endcase
                off[0] = 1'($urandom_range(0, 1));
                c = 16'($urandom);
                c[7:0]   = off;
                c[13:12] = 2'($urandom_range(0, 3));
                bus_cmd(c);
            end
            if ($urandom_range(0, 1) == 0) begin
                bus_write(16'($urandom));
            end else begin
                exp = model_read();
                bus_read(d, lat);
                checks++;
                if (d !== exp) begin
                    errors++;
                    $display("FAIL rand_read: off=%h be=%b got %h expected %h", moff, mbe, d, exp);
                end
                checks++;
                if (lat != S + 2) begin errors++; $display("FAIL rand_latency: got %0d expected %0d", lat, S + 2); end
            end
            checks++;
            if (INTRN !== model_intrn()) begin
                errors++;
                $display("FAIL rand_intrn: got %b expected %b", INTRN, model_intrn());
            end
        end
    endtask

    task automatic test_irq();
        bus_cmd(16'h3090);
        bus_write(16'h0004);
        checks++;
        if (INTRN !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", INTRN); end
        @(negedge clk40m); irq_set = 16'h0004;
        mregs['h49] = mregs['h49] | 16'h0004;
        checks++;
        if (INTRN !== 1'b1) begin errors++; $display("FAIL irq_not_comb: got %b expected 1", INTRN); end
        @(posedge clk40m); #1;
        checks++;
        if (INTRN !== 1'b0) begin errors++; $display("FAIL irq_assert: got %b expected 0", INTRN); end
        @(negedge clk40m); irq_set = 16'h0;
        bus_cmd(16'h3092);
        bus_write(16'h0004);
        checks++;
        if (INTRN !== model_intrn() || INTRN !== 1'b1) begin
            errors++; $display("FAIL irq_w1c: got %b expected 1", INTRN);
        end
    endtask

    task automatic test_irq_race();
        logic [15:0] d;
        int lat;
        logic went_high;
        @(negedge clk40m); irq_set = 16'h0004;
        @(negedge clk40m); irq_set = 16'h0;
        mregs['h49] = mregs['h49] | 16'h0004;
        bus_cmd(16'h3092);
        @(negedge clk40m);
        CSN = 1'b0; CMD = 1'b0; SD_in = 16'h0004;
        hold(1); WRN = 1'b0;
        hold(3); WRN = 1'b1;
        went_high = 1'b0;
        for (int i = 1; i <= S + 4; i++) begin
            @(negedge clk40m);
            irq_set = (i == S) ? 16'h0004 : 16'h0000;
            if (INTRN !== 1'b0) went_high = 1'b1;
        end
        CSN = 1'b1;
        hold(2);
        model_write(16'h0004);
        mregs['h49] = mregs['h49] | 16'h0004;
        checks++;
        if (went_high !== 1'b0) begin errors++; $display("FAIL race_intrn: got glitch=%b expected 0", went_high); end
        bus_read(d, lat);
        checks++;
        if (d !== 16'h0004 || d !== model_read()) begin
            errors++; $display("FAIL race_isr: got %h expected 0004", d);
        end
        bus_write(16'h0004);
        checks++;
        if (INTRN !== 1'b1) begin errors++; $display("FAIL race_cleanup: got %b expected 1", INTRN); end
    endtask

    task automatic test_proto_err();
        logic [15:0] d;
        int lat, pulses, oe_seen;
        bus_cmd(16'h3014);
        bus_write(16'hBEEF);
        for (int v = 0; v < 2; v++) begin
            @(negedge clk40m);
            CSN = 1'b0; CMD = 1'b0; SD_in = 16'h1234;
            hold(1);
            WRN = 1'b0;
            if (v == 1) hold(3);
            RDN = 1'b0;
            pulses = 0; oe_seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk40m);
                if (proto_err === 1'b1) pulses++;
                if (SD_oe !== 1'b0) oe_seen++;
            end
            RDN = 1'b1; WRN = 1'b1;
            hold(S + 4); CSN = 1'b1;
            hold(2);
            checks++;
            if (pulses != 1) begin errors++; $display("FAIL proto_pulses v%0d: got %0d expected 1", v, pulses); end
            checks++;
            if (oe_seen != 0) begin errors++; $display("FAIL proto_oe v%0d: got %0d expected 0", v, oe_seen); end
            bus_read(d, lat);
            checks++;
            if (d !== 16'hBEEF) begin errors++; $display("FAIL proto_nowrite v%0d: got %h expected BEEF", v, d); end
        end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        int lat, ok;
        bus_cmd(16'h3016);
        bus_write(16'hC3C3);
        @(negedge clk40m);
        CSN = 1'b0; CMD = 1'b0;
        hold(1); RDN = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin @(negedge clk40m); if (SD_oe === 1'b1) ok = 1; end
        checks++;
        if (ok != 1) begin errors++; $display("FAIL abort_read_start: got oe=%b expected 1", SD_oe); end
        CSN = 1'b1;
        ok = 0;
        for (int i = 0; i < S + 3 && ok == 0; i++) begin @(negedge clk40m); if (SD_oe === 1'b0) ok = 1; end
        checks++;
        if (ok != 1) begin errors++; $display("FAIL abort_read_oe: got oe=%b expected 0", SD_oe); end
        RDN = 1'b1;
        hold(S + 4);
        @(negedge clk40m);
        CSN = 1'b0; CMD = 1'b0; SD_in = 16'h1111;
        hold(1); WRN = 1'b0;
        hold(3); CSN = 1'b1;
        hold(S + 3); WRN = 1'b1;
        hold(S + 4);
        bus_read(d, lat);
        checks++;
        if (d !== 16'hC3C3) begin errors++; $display("FAIL abort_write: got %h expected C3C3", d); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        int lat, ok;
        bus_cmd(16'h3020);
        bus_write(16'h1111);
        @(negedge clk40m);
        CSN = 1'b0; CMD = 1'b0; SD_in = 16'h5A5A;
        hold(1); WRN = 1'b0;
        hold(S + 2);
        reset = 1'b1;
        model_reset();
        hold(2);
        reset = 1'b0;
        hold(S + 4); WRN = 1'b1;
        hold(S + 4); CSN = 1'b1;
        hold(2);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_no_false_edge: got %h expected 0000", d); end
        bus_cmd(16'h3020);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_mid_write: got %h expected 0000", d); end
        bus_write(16'h2222);
        @(negedge clk40m);
        CSN = 1'b0; CMD = 1'b0;
        hold(1); RDN = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin @(negedge clk40m); if (SD_oe === 1'b1) ok = 1; end
        reset = 1'b1;
        #1;
        checks++;
        if (ok != 1 || SD_oe !== 1'b0 || SD_out !== 16'h0 || INTRN !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_read: got started=%0d oe=%b out=%h intrn=%b expected 1 0 0000 1",
                     ok, SD_oe, SD_out, INTRN);
        end
        model_reset();
        RDN = 1'b1; CSN = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(2);
        bus_cmd(16'h3020);
        bus_read(d, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_clears: got %h expected 0000", d); end
    endtask

    initial begin
        test_reset();
        test_chip_id();
        test_byte_enable();
        test_random();
        test_irq();
        test_irq_race();
        test_proto_err();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ks_bus_responder.md
KS_BUS_RESPONDER -- requirements
Module: ks_bus_responder

Interface
REQ-001 Parameter CHIP_ID, default 16'h8870, value returned at register offset 8'hC0 (read-only).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on CSN, CMD, RDN, WRN and SD_in (min 2).
REQ-003 clk40m  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 CSN  input  1  host chip select, active low.
REQ-006 CMD  input  1  1 = command (address) cycle, 0 = data cycle.
REQ-007 RDN  input  1  host read strobe, active low.
REQ-008 WRN  input  1  host write strobe, active low.
REQ-009 SD_in  input  16  host bus data in.
REQ-010 SD_out  output  16  read data to host bus.
REQ-011 SD_oe  output  1  1 = responder drives SD.
REQ-012 INTRN  output  1  interrupt to host, active low.
REQ-013 irq_set  input  16  single-cycle pulses that set the matching ISR bits.
REQ-014 proto_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-015 Inputs CSN, CMD, RDN, WRN and SD_in shall pass through SYNC_STAGES flops, all aligned to one another.
REQ-016 Strobe edges shall come from the synchronized signals: fall = previous 1, now 0; rise = previous 0, now 1.
REQ-017 Register file: 128 x 16-bit words, indexed by the latched byte offset[7:1]; offset bit 0 is ignored.
REQ-018 Offset C0h shall read CHIP_ID, and writes to it shall be discarded.
REQ-019 Offset 90h is IER (read/write).
REQ-020 Offset 92h is ISR, write-1-to-clear; all other offsets are plain read/write.
REQ-021 FSM states: IDLE, CMD_WR, DATA_WR, DATA_RD, ERR.
REQ-022 IDLE -> CMD_WR on WRN fall with CSN=0 and CMD=1.
REQ-023 IDLE -> DATA_WR on WRN fall with CSN=0 and CMD=0.
REQ-024 IDLE -> DATA_RD on RDN fall with CSN=0 and CMD=0.
REQ-025 RDN fall with CMD=1 shall be ignored; the FSM stays in IDLE.
REQ-026 CMD_WR: on WRN rise, latch offset = SD[7:0] and byte enables BE = SD[13:12] (bit 12 = low byte, bit 13 = high byte), then go to IDLE.
REQ-027 DATA_WR: on WRN rise, write SD to the addressed word, updating only the bytes enabled by BE, then go to IDLE.
REQ-028 A write pulse to ISR shall clear every ISR bit written with 1 in an enabled byte.
REQ-029 DATA_RD: SD_out shall be loaded with the addressed word, with disabled bytes forced to 0.
REQ-030 SD_oe shall be 1 from the cycle after RDN fall is detected until the cycle after RDN rise is detected, then the FSM returns to IDLE.
REQ-031 Read latency: SD_oe shall rise exactly SYNC_STAGES+2 clk40m cycles after the raw RDN falls.
REQ-032 Offset and BE shall persist across data cycles, with no auto-increment, until the next command cycle.
REQ-033 Synchronized RDN and WRN both 0 while CSN=0 shall cause proto_err = 1 for one cycle, SD_oe = 0, no write, and entry to ERR.
REQ-034 ERR -> IDLE once both strobes are 1; the offset latch shall remain unchanged.
REQ-035 CSN rise in any non-IDLE state shall abort to IDLE with SD_oe = 0 and no write committed.
REQ-036 ISR(next) = (ISR & ~w1c_mask) | irq_set; on the same bit, a set wins over a clear.
REQ-037 INTRN shall be registered, equal to ~|(ISR & IER).

Reset
REQ-038 While reset = 1, asynchronously: FSM = IDLE, SD_oe = 0, SD_out = 0, INTRN = 1, proto_err = 0.
REQ-039 While reset = 1, asynchronously: offset = 0, BE = 2'b11, all register words = 0 (CHIP_ID unaffected), synchronizers = idle (CSN, RDN, WRN = 1).
REQ-040 Reset asserted mid-transaction shall abandon it with no partial write.
REQ-041 After reset release, strobes already low shall not generate a fall edge.

Verification
REQ-042 Command cycle SD=16'h30C0, then read -> SD_oe rises SYNC_STAGES+2 cycles after RDN falls, SD_out = 16'h8870.
REQ-043 Command SD=16'h1010, write SD=16'hABCD, command SD=16'h3010, read -> SD_out = 16'h00CD.
REQ-044 IER = 16'h0004, irq_set bit 2 pulsed -> INTRN = 0 one cycle later; write ISR 16'h0004 -> INTRN = 1.
REQ-045 irq_set bit 2 in the same cycle as a W1C write of bit 2 -> ISR[2] stays 1, INTRN stays 0.
REQ-046 RDN and WRN both low with CSN=0 -> single proto_err pulse, SD_oe = 0, register file unchanged.
REQ-047 CSN raised mid-read, and separately reset asserted mid-write -> SD_oe = 0 and the target word is unchanged.
